// File: rtl/adc_emulator_if.sv
// Conversion handshake and playback-buffer write bus between the sample manager
// (master) and the ADC emulator (slave).
interface adc_emulator_if #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned ADDR_WIDTH = 11
);
  logic                  convst;
  logic                  busy;
  logic [DATA_WIDTH-1:0] data;
  logic                  data_rdy;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output convst, wr_en, wr_addr, wr_data,
    input  busy, data, data_rdy
  );

  modport slave (
    input  convst, wr_en, wr_addr, wr_data,
    output busy, data, data_rdy
  );
endinterface

// File: rtl/adc_emulator.sv
// ADC conversion responder: answers convst edges with a fixed busy time, then plays the
// next word of a loadable buffer. Define ADC_EMU_DITHER_EN to add LFSR noise on the 2 LSBs.
module adc_emulator #(
  parameter int unsigned DATA_WIDTH  = 12,
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned BUSY_CYCLES = 100
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [ADDR_WIDTH-1:0] i_last_addr,
  output logic [ADDR_WIDTH-1:0] o_sample_idx,
  output logic                  o_overrun,
  adc_emulator_if.slave         adc
);

  localparam int unsigned CntW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(BUSY_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic                  convst_q;
  logic                  busy_q;
  logic                  rdy_q;
  logic                  overrun_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  start_edge;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  assign start_edge = adc.convst & ~convst_q;

  // Write port has no reset so the buffer maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (adc.wr_en) begin
      mem[adc.wr_addr] <= adc.wr_data;
    end
  end

`ifdef ADC_EMU_DITHER_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lfsr_q <= 16'hACE1;
    end else if (i_en && state_q == StDone) begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  assign rd_word = mem[idx_q] ^ {{(DATA_WIDTH-2){1'b0}}, lfsr_q[1:0]};
`else
  assign rd_word = mem[idx_q];
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      convst_q  <= 1'b0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b0;
      overrun_q <= 1'b0;
      data_q    <= '0;
      idx_q     <= '0;
    end else begin
      convst_q <= adc.convst;
      rdy_q    <= 1'b0;
      if (start_edge && i_en && state_q != StIdle) begin
        overrun_q <= 1'b1;
      end
      if (!i_en) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_edge) begin
              state_q <= StConv;
              busy_q  <= 1'b1;
              cnt_q   <= CntLoad;
            end
          end
          StConv: begin
            if (cnt_q == '0) begin
              // Registered read lands in the DONE cycle alongside the ready pulse.
              data_q  <= rd_word;
              state_q <= StDone;
              busy_q  <= 1'b0;
              rdy_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
          StDone: begin
            idx_q   <= (idx_q >= i_last_addr) ? '0 : idx_q + ADDR_WIDTH'(1);
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign adc.busy     = busy_q;
  assign adc.data     = data_q;
  assign adc.data_rdy = rdy_q;
  assign o_sample_idx = idx_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_adc_emulator.sv
// Scoreboard bench for adc_emulator: stimulus pushes expected samples and ready cycles,
// a negedge monitor pops and compares on every data-ready pulse.
module tb_adc_emulator;

  localparam int unsigned DW = 12;
  localparam int unsigned AW = 11;
  localparam int unsigned B  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [AW-1:0] sample_idx;
  logic          overrun;

  adc_emulator_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) adc ();

  adc_emulator #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BUSY_CYCLES(B)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_last_addr  (last_addr),
    .o_sample_idx (sample_idx),
    .o_overrun    (overrun),
    .adc          (adc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchecks = 0;
  int nfail   = 0;

  logic [DW-1:0] exp_data_q [$];
  int            exp_cyc_q  [$];
  logic [DW-1:0] mem_m [4];
  logic [AW-1:0] idx_m = '0;
  logic [15:0]   lfsr_m = 16'hACE1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model of the next played word; advances the bench's index and LFSR copies.
  task automatic push_exp();
    logic [DW-1:0] w;
    w = mem_m[idx_m[1:0]];
`ifdef ADC_EMU_DITHER_EN
    w = w ^ {{(DW-2){1'b0}}, lfsr_m[1:0]};
    lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
`endif
    exp_data_q.push_back(w);
    exp_cyc_q.push_back(cyc + B + 1);
    idx_m = (idx_m >= last_addr) ? '0 : idx_m + AW'(1);
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    tick(1);
    adc.wr_en   = 1'b1;
    adc.wr_addr = a;
    adc.wr_data = d;
    mem_m[a[1:0]] = d;
    tick(1);
    adc.wr_en = 1'b0;
  endtask

  // One-cycle convst pulse starting in the current cycle.
  task automatic pulse(input bit expect_rdy);
    tick(1);
    adc.convst = 1'b1;
    if (expect_rdy) push_exp();
    tick(1);
    adc.convst = 1'b0;
  endtask

  // Monitor: pops one expectation per ready pulse and checks width, busy run and latency.
  int   busy_run = 0;
  logic prev_rdy = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
      prev_rdy = 1'b0;
    end else begin
      if (adc.data_rdy) begin
        chk("rdy_width", {31'b0, prev_rdy}, 32'd0);
        chk("busy_at_rdy", {31'b0, adc.busy}, 32'd0);
        chk("busy_len", busy_run, B);
        if (exp_data_q.size() == 0) begin
          nchecks++;
          nfail++;
          $display("FAIL unexpected_rdy: got data 0x%0h, expected no pulse (cycle %0d)",
                   adc.data, cyc);
        end else begin
          chk("data", {20'b0, adc.data}, {20'b0, exp_data_q.pop_front()});
          chk("rdy_cycle", cyc, exp_cyc_q.pop_front());
        end
        busy_run = 0;
      end else if (adc.busy) begin
        busy_run++;
      end else begin
        busy_run = 0;
      end
      prev_rdy = adc.data_rdy;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'b0, adc.busy}, 32'd0);
    chk({tag, "_data"}, {20'b0, adc.data}, 32'd0);
    chk({tag, "_rdy"}, {31'b0, adc.data_rdy}, 32'd0);
    chk({tag, "_idx"}, {21'b0, sample_idx}, 32'd0);
    chk({tag, "_overrun"}, {31'b0, overrun}, 32'd0);
  endtask

  initial begin
    adc.convst  = 1'b0;
    adc.wr_en   = 1'b0;
    adc.wr_addr = '0;
    adc.wr_data = '0;
    tick(3);
    rst = 1'b0;
    chk_reset_outputs("reset");

    write_word(11'd0, 12'h100);
    write_word(11'd1, 12'h7FF);
    write_word(11'd2, 12'h000);
    write_word(11'd3, 12'hFFF);
    last_addr = 11'd3;
    en = 1'b1;
    tick(2);

    // Five spaced conversions, wrapping after address 3.
    for (int i = 0; i < 5; i++) begin
      pulse(1'b1);
      tick(18);
    end
    chk("idx_after_wrap", {21'b0, sample_idx}, 32'd1);
    chk("queue_empty_seq", exp_data_q.size(), 0);

    // Level held high: one conversion only.
    tick(1);
    adc.convst = 1'b1;
    push_exp();
    tick(50);
    adc.convst = 1'b0;
    tick(10);
    chk("queue_empty_hold", exp_data_q.size(), 0);
    chk("overrun_after_hold", {31'b0, overrun}, 32'd0);

    // Second edge two cycles into CONV is ignored but flagged.
    pulse(1'b1);
    tick(1);
    adc.convst = 1'b1;
    tick(1);
    adc.convst = 1'b0;
    tick(1);
    chk("overrun_set", {31'b0, overrun}, 32'd1);
    tick(20);
    chk("overrun_sticky", {31'b0, overrun}, 32'd1);
    chk("queue_empty_ovr", exp_data_q.size(), 0);

    // Enable dropped on busy cycle 2: abort, index kept.
    pulse(1'b0);
    en = 1'b0;
    tick(1);
    chk("busy_after_en_drop", {31'b0, adc.busy}, 32'd0);
    tick(10);
    chk("idx_after_en_drop", {21'b0, sample_idx}, {21'b0, idx_m});
    en = 1'b1;
    tick(2);
    pulse(1'b1);
    tick(18);
    chk("queue_empty_en", exp_data_q.size(), 0);

    // Reset mid-conversion: outputs clear, playback restarts at address 0.
    pulse(1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    idx_m  = '0;
    lfsr_m = 16'hACE1;
    chk_reset_outputs("mid_reset");
    tick(2);
    pulse(1'b1);
    tick(18);
    chk("queue_empty_rst", exp_data_q.size(), 0);

`ifdef ADC_EMU_DITHER_EN
    for (int a = 0; a < 4; a++) write_word(AW'(a), 12'h400);
    for (int i = 0; i < 6; i++) begin
      pulse(1'b1);
      tick(5);
      chk("dither_msbs", {22'b0, adc.data[DW-1:2]}, 32'h100);
      tick(13);
    end
`endif

    tick(10);
    chk("queue_empty_end", exp_data_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

endmodule
